systolic_matmul_sequencer: RTL and testbench

//  Sequences one N_SIZE x N_SIZE matrix multiply on systolic_array. Host loads A and B row

---
 rtl/systolic_matmul_sequencer_if.sv | 34 +++
 rtl/systolic_matmul_sequencer.sv | 164 ++++++++++++++++
 tb/tb_systolic_matmul_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_matmul_sequencer_if.sv
// rtl/systolic_matmul_sequencer_if.sv - systolic array link and result row stream
// master = sequencer side, slave = array model / result consumer side.
interface systolic_matmul_sequencer_if #(
  parameter int DATAWIDTH = 16,
  parameter int N_SIZE    = 5
);
  localparam int AW = $clog2(N_SIZE);

  logic                          sa_valid_in;
  logic [N_SIZE*DATAWIDTH-1:0]   sa_matrix_a;
  logic [N_SIZE*DATAWIDTH-1:0]   sa_matrix_b;
  logic                          sa_valid_out;
  logic [N_SIZE*2*DATAWIDTH-1:0] sa_matrix_c;

  logic                          c_valid;
  logic                          c_ready;
  logic [N_SIZE*2*DATAWIDTH-1:0] c_data;
  logic [AW-1:0]                 c_row;
  logic                          c_last;

  modport master (
    output sa_valid_in, sa_matrix_a, sa_matrix_b,
    input  sa_valid_out, sa_matrix_c,
    output c_valid, c_data, c_row, c_last,
    input  c_ready
  );

  modport slave (
    input  sa_valid_in, sa_matrix_a, sa_matrix_b,
    output sa_valid_out, sa_matrix_c,
    input  c_valid, c_data, c_row, c_last,
    output c_ready
  );
endinterface

// File: rtl/systolic_matmul_sequencer.sv
// rtl/systolic_matmul_sequencer.sv - feeds A/B rows to a systolic array, collects and streams C rows
// Define SYSTOLIC_SEQ_PERF_EN to enable the perf_cycles job counter.
module systolic_matmul_sequencer #(
  parameter  int DATAWIDTH      = 16,
  parameter  int N_SIZE         = 5,
  parameter  int TIMEOUT_CYCLES = 64,
  localparam int AW             = $clog2(N_SIZE)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  output logic                        err,
  input  logic                        a_wr_en,
  input  logic [AW-1:0]               a_wr_row,
  input  logic [N_SIZE*DATAWIDTH-1:0] a_wr_data,
  input  logic                        b_wr_en,
  input  logic [AW-1:0]               b_wr_row,
  input  logic [N_SIZE*DATAWIDTH-1:0] b_wr_data,
  output logic [31:0]                 perf_cycles,
  systolic_matmul_sequencer_if.master bus
);
  localparam int RW = N_SIZE * DATAWIDTH;
  localparam int CW = 2 * RW;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [AW:0]   ROWS     = (AW+1)'(N_SIZE);
  localparam logic [AW:0]   LAST_ROW = (AW+1)'(N_SIZE - 1);
  localparam logic [TW-1:0] TO_LIMIT = TW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_FEED, S_COLLECT, S_OUTPUT} state_t;

  state_t                     state_q, state_d;
  logic [N_SIZE-1:0][RW-1:0]  a_q, a_d;
  logic [N_SIZE-1:0][RW-1:0]  b_q, b_d;
  logic [N_SIZE-1:0][CW-1:0]  c_q, c_d;
  logic [AW:0]                idx_q, idx_d;
  logic [AW:0]                cap_q, cap_d;
  logic [TW-1:0]              to_q, to_d;
  logic                       err_q, err_d;
  logic                       capture;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    idx_d   = idx_q;
    cap_d   = cap_q;
    to_d    = to_q;
    err_d   = err_q;
    done    = 1'b0;

    // The array may answer while beats are still going in, so FEED captures too.
    capture = bus.sa_valid_out && (state_q == S_FEED || state_q == S_COLLECT) && (cap_q < ROWS);
    if (capture) begin
      c_d[cap_q[AW-1:0]] = bus.sa_matrix_c;
      cap_d = cap_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (a_wr_en && ({1'b0, a_wr_row} < ROWS)) a_d[a_wr_row] = a_wr_data;
        if (b_wr_en && ({1'b0, b_wr_row} < ROWS)) b_d[b_wr_row] = b_wr_data;
        if (start) begin
          state_d = S_FEED;
          err_d   = 1'b0;
          idx_d   = '0;
          cap_d   = '0;
          to_d    = '0;
        end
      end
      S_FEED: begin
        if (idx_q == LAST_ROW) begin
          state_d = S_COLLECT;
          idx_d   = '0;
          to_d    = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_COLLECT: begin
        to_d = to_q + 1'b1;
        if (cap_d == ROWS) begin
          state_d = S_OUTPUT;
        end else if (capture) begin
          to_d = '0;
        end else if (to_d == TO_LIMIT) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end
      end
      S_OUTPUT: begin
        if (bus.c_ready) begin
          if (idx_q == LAST_ROW) begin
            done    = 1'b1;
            state_d = S_IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      idx_q   <= '0;
      cap_q   <= '0;
      to_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      idx_q   <= idx_d;
      cap_q   <= cap_d;
      to_q    <= to_d;
      err_q   <= err_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign err  = err_q;

  assign bus.sa_valid_in = (state_q == S_FEED);
  assign bus.sa_matrix_a = (state_q == S_FEED) ? a_q[idx_q[AW-1:0]] : '0;
  assign bus.sa_matrix_b = (state_q == S_FEED) ? b_q[idx_q[AW-1:0]] : '0;

  assign bus.c_valid = (state_q == S_OUTPUT);
  assign bus.c_data  = (state_q == S_OUTPUT) ? c_q[idx_q[AW-1:0]] : '0;
  assign bus.c_row   = (state_q == S_OUTPUT) ? idx_q[AW-1:0] : '0;
  assign bus.c_last  = (state_q == S_OUTPUT) && (idx_q == LAST_ROW);

`ifdef SYSTOLIC_SEQ_PERF_EN
  logic [31:0] perf_q, perf_d;

  // Counts every non-idle cycle, so the done cycle is included and IDLE holds the result.
  always_comb begin
    perf_d = perf_q;
    if (state_q == S_IDLE) begin
      if (start) perf_d = '0;
    end else begin
      perf_d = perf_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) perf_q <= '0;
    else        perf_q <= perf_d;
  end

  assign perf_cycles = perf_q;
`else
  assign perf_cycles = 32'd0;
`endif
endmodule

// File: tb/tb_systolic_matmul_sequencer.sv
// tb/tb_systolic_matmul_sequencer.sv - bench for systolic_matmul_sequencer with a fixed-latency array model
module tb_systolic_matmul_sequencer;
  localparam int DW = 16;
  localparam int N  = 5;
  localparam int TO = 64;
  localparam int AW = $clog2(N);
  localparam int L  = 3;
  localparam int RW = N * DW;
  localparam int CW = 2 * RW;

  typedef struct {
    int a_kind;       // 0 identity/sequence, 1 random, 2 keep buffers
    int ready_mode;   // 0 always, 1 toggle, 2 random
    bit silent;
    bit extra;
    bit wr_at_start;
    bit poke;
    int exp_rows;
    int exp_done;
    bit exp_err;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, err;
  logic          a_wr_en = 1'b0, b_wr_en = 1'b0;
  logic [AW-1:0] a_wr_row = '0, b_wr_row = '0;
  logic [RW-1:0] a_wr_data = '0, b_wr_data = '0;
  logic [31:0]   perf_cycles;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int sh_a [N][N];
  int sh_b [N][N];
  bit mdl_silent = 1'b0;
  bit mdl_extra = 1'b0;
  bit last_err = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  systolic_matmul_sequencer_if #(.DATAWIDTH(DW), .N_SIZE(N)) bus ();

  systolic_matmul_sequencer #(.DATAWIDTH(DW), .N_SIZE(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .err(err),
    .a_wr_en(a_wr_en), .a_wr_row(a_wr_row), .a_wr_data(a_wr_data),
    .b_wr_en(b_wr_en), .b_wr_row(b_wr_row), .b_wr_data(b_wr_data),
    .perf_cycles(perf_cycles), .bus(bus)
  );

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [RW-1:0] pack_a(input int i);
    logic [RW-1:0] r;
    for (int j = 0; j < N; j++) r[j*DW +: DW] = DW'(sh_a[i][j]);
    return r;
  endfunction

  function automatic logic [RW-1:0] pack_b(input int i);
    logic [RW-1:0] r;
    for (int j = 0; j < N; j++) r[j*DW +: DW] = DW'(sh_b[i][j]);
    return r;
  endfunction

  // Expected C row from the host-side matrices: C = A x B, 32-bit words.
  function automatic logic [CW-1:0] ref_row(input int i);
    logic [CW-1:0] r;
    logic [31:0]   acc;
    for (int j = 0; j < N; j++) begin
      acc = '0;
      for (int k = 0; k < N; k++) acc = acc + 32'(sh_a[i][k]) * 32'(sh_b[k][j]);
      r[j*2*DW +: 2*DW] = acc;
    end
    return r;
  endfunction

  function automatic logic [CW-1:0] model_row(input logic [RW-1:0] ma [N], input logic [RW-1:0] mb [N], input int i);
    logic [CW-1:0] r;
    logic [31:0]   acc;
    for (int j = 0; j < N; j++) begin
      acc = '0;
      for (int k = 0; k < N; k++) acc = acc + 32'(ma[i][k*DW +: DW]) * 32'(mb[k][j*DW +: DW]);
      r[j*2*DW +: 2*DW] = acc;
    end
    return r;
  endfunction

  // Array model: latches the beats it is fed, emits N result rows L cycles after the last beat.
  initial begin
    logic [RW-1:0] ma [N];
    logic [RW-1:0] mb [N];
    int bc, f, k;
    bc = 0;
    f  = -100000;
    bus.sa_valid_out = 1'b0;
    bus.sa_matrix_c  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bc = 0;
        f  = -100000;
        bus.sa_valid_out = 1'b0;
        bus.sa_matrix_c  = '0;
      end else begin
        if (bus.sa_valid_in) begin
          ma[bc] = bus.sa_matrix_a;
          mb[bc] = bus.sa_matrix_b;
          bc++;
          if (bc == N) begin
            bc = 0;
            f  = cyc;
          end
        end
        k = cyc - f - L;
        if (!mdl_silent && k >= 0 && k < N + (mdl_extra ? 1 : 0)) begin
          bus.sa_valid_out = 1'b1;
          bus.sa_matrix_c  = (k < N) ? model_row(ma, mb, k) : CW'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
        end else begin
          bus.sa_valid_out = 1'b0;
          bus.sa_matrix_c  = '0;
        end
      end
    end
  end

  task automatic load_mats(input int kind);
    if (kind == 2) return;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        sh_a[i][j] = (kind == 0) ? ((i == j) ? 1 : 0) : int'($urandom_range(0, 65535));
        sh_b[i][j] = (kind == 0) ? (i * N + j + 1) : int'($urandom_range(0, 65535));
      end
      @(negedge clk);
      a_wr_en = 1'b1; a_wr_row = AW'(i); a_wr_data = pack_a(i);
      b_wr_en = 1'b1; b_wr_row = AW'(i); b_wr_data = pack_b(i);
    end
    // Out-of-range rows must be dropped without touching the buffers.
    for (int i = N; i < (1 << AW); i++) begin
      @(negedge clk);
      a_wr_row  = AW'(i); a_wr_data = RW'({$urandom(), $urandom(), $urandom()});
      b_wr_row  = AW'(i); b_wr_data = RW'({$urandom(), $urandom(), $urandom()});
    end
  endtask

  task automatic run_job(input vec_t v);
    int t, y, beats, first_beat, last_beat, nrows, ndone, err_cycle, stall_bad;
    bit err_busy, pv, pr, fin;
    logic [CW-1:0] pd;
    logic [AW-1:0] prow;
    mdl_silent = v.silent;
    mdl_extra  = v.extra;
    load_mats(v.a_kind);
    @(negedge clk);
    check("err_sticky", 256'(err), 256'(last_err));
    a_wr_en = 1'b0;
    b_wr_en = 1'b0;
    if (v.wr_at_start) begin
      a_wr_en = 1'b1; a_wr_row = AW'(2); a_wr_data = {N{16'h0003}};
      for (int j = 0; j < N; j++) sh_a[2][j] = 3;
    end
    start = 1'b1;
    t = cyc;
    beats = 0; first_beat = -1; last_beat = -1; nrows = 0; ndone = 0;
    err_cycle = -1; err_busy = 1'b0; stall_bad = 0; pv = 1'b0; pr = 1'b0; pd = '0; prow = '0; fin = 1'b0;
    for (int n = 0; n < 400 && !fin; n++) begin
      @(negedge clk);
      y = cyc;
      start = 1'b0; a_wr_en = 1'b0; b_wr_en = 1'b0;
      if (v.poke && y == t + 2) begin
        start = 1'b1;
        a_wr_en = 1'b1; a_wr_row = AW'(0); a_wr_data = RW'({$urandom(), $urandom(), $urandom()});
        b_wr_en = 1'b1; b_wr_row = AW'(1); b_wr_data = RW'({$urandom(), $urandom(), $urandom()});
      end
      case (v.ready_mode)
        0:       bus.c_ready = 1'b1;
        1:       bus.c_ready = y[0];
        default: bus.c_ready = $urandom_range(0, 1) == 1;
      endcase
      #1;
      if (y == t + 1) begin
        check("busy_at_feed", 256'(busy), 256'(1));
        check("err_cleared", 256'(err), 256'(0));
      end
      if (bus.sa_valid_in) begin
        if (first_beat < 0) first_beat = y;
        last_beat = y;
        if (beats < N) begin
          check($sformatf("beat%0d_a", beats), 256'(bus.sa_matrix_a), 256'(pack_a(beats)));
          check($sformatf("beat%0d_b", beats), 256'(bus.sa_matrix_b), 256'(pack_b(beats)));
        end
        beats++;
      end
      if (pv && !pr && (bus.c_data !== pd || bus.c_row !== prow)) stall_bad++;
      if (bus.c_valid && bus.c_ready && nrows < N) begin
        check("c_row", 256'(bus.c_row), 256'(nrows));
        check($sformatf("c_data_row%0d", nrows), 256'(bus.c_data), 256'(ref_row(nrows)));
        check("c_last", 256'(bus.c_last), 256'(nrows == N - 1));
        nrows++;
      end
      if (done) ndone++;
      if (err && err_cycle < 0) begin
        err_cycle = y;
        err_busy  = busy;
      end
      pv = bus.c_valid; pr = bus.c_ready; pd = bus.c_data; prow = bus.c_row;
      fin = (ndone > 0) || (err && !busy);
    end
    if (!fin) check("job_bound", 256'(0), 256'(1));
    @(negedge clk);
    bus.c_ready = 1'b0;
    #1;
    check("busy_after", 256'(busy), 256'(0));
    check("done_once", 256'(done), 256'(0));
    check("c_valid_after", 256'(bus.c_valid), 256'(0));
`ifdef SYSTOLIC_SEQ_PERF_EN
    if (v.ready_mode == 0 && !v.silent) check("perf_cycles", 256'(perf_cycles), 256'(3 * N + L - 1));
`else
    check("perf_off", 256'(perf_cycles), 256'(0));
`endif
    check("beats", 256'(beats), 256'(N));
    check("first_beat", 256'(first_beat), 256'(t + 1));
    check("last_beat", 256'(last_beat), 256'(t + N));
    check("rows", 256'(nrows), 256'(v.exp_rows));
    check("done_count", 256'(ndone), 256'(v.exp_done));
    check("err_final", 256'(err), 256'(v.exp_err));
    check("stall_stable", 256'(stall_bad), 256'(0));
    if (v.exp_err) begin
      check("err_cycle", 256'(err_cycle), 256'(t + N + 1 + TO));
      check("err_busy", 256'(err_busy), 256'(0));
    end
    last_err = v.exp_err;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 256'(busy), 256'(0));
    check({tag, "_done"}, 256'(done), 256'(0));
    check({tag, "_err"}, 256'(err), 256'(0));
    check({tag, "_c_valid"}, 256'(bus.c_valid), 256'(0));
    check({tag, "_c_data"}, 256'(bus.c_data), 256'(0));
    check({tag, "_c_row_last"}, 256'({bus.c_row, bus.c_last}), 256'(0));
    check({tag, "_sa_in"}, 256'({bus.sa_valid_in, bus.sa_matrix_a, bus.sa_matrix_b}), 256'(0));
    check({tag, "_perf"}, 256'(perf_cycles), 256'(0));
  endtask

  initial begin
    vec_t tbl [7];
    vec_t v_keep, v_rand;
    int t;
    tbl[0] = '{0, 0, 1'b0, 1'b0, 1'b0, 1'b0, N, 1, 1'b0};
    tbl[1] = '{0, 1, 1'b0, 1'b0, 1'b0, 1'b0, N, 1, 1'b0};
    tbl[2] = '{0, 0, 1'b0, 1'b0, 1'b1, 1'b0, N, 1, 1'b0};
    tbl[3] = '{1, 2, 1'b0, 1'b1, 1'b0, 1'b0, N, 1, 1'b0};
    tbl[4] = '{1, 0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1};
    tbl[5] = '{2, 1, 1'b0, 1'b0, 1'b0, 1'b1, N, 1, 1'b0};
    tbl[6] = '{2, 0, 1'b0, 1'b0, 1'b0, 1'b0, N, 1, 1'b0};
    v_keep = '{2, 0, 1'b0, 1'b0, 1'b0, 1'b0, N, 1, 1'b0};
    v_rand = '{1, 2, 1'b0, 1'b0, 1'b0, 1'b0, N, 1, 1'b0};
    bus.c_ready = 1'b0;

    repeat (3) @(negedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run_job(tbl[i]);

    // Reset while the sequencer waits in COLLECT.
    mdl_silent = 1'b0;
    mdl_extra  = 1'b0;
    load_mats(1);
    @(negedge clk);
    a_wr_en = 1'b0; b_wr_en = 1'b0; start = 1'b1;
    t = cyc;
    repeat (N + 2) begin
      @(negedge clk);
      start = 1'b0;
    end
    #1;
    check("mid_job_busy", 256'(busy), 256'(1));
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        sh_a[i][j] = 0;
        sh_b[i][j] = 0;
      end
    last_err = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_job(v_keep);
    run_job(v_rand);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
